i2s_pcm1702_framer: RTL and testbench
=====================================

// Module: i2s_pcm1702_framer
// PURPOSE
//  Frame-locked I2S receiver and dual PCM1702 word serializer. It sits between the
//  I2S input (BCK/LRCK/DATAIN) and the two PCM1702 DACs, and replaces the free-running
//  shift-delay path. It checks I2S framing, captures a left/right word pair per frame,
//  and re-emits both channels simultaneously, right-justified, with one common latch
//  enable. It outputs zeros (mute) whenever framing is not locked.
// PARAMETERS
//  SLOT_BITS   32  BCK cycles per channel slot; a frame is 2*SLOT_BITS cycles
//  WORD_BITS   24  I2S bits captured per channel, MSB first; WORD_BITS<=SLOT_BITS
//  OUT_BITS    20  bits sent to each PCM1702 (word MSBs); OUT_BITS<=WORD_BITS, <SLOT_BITS
//  LOCK_FRAMES 4   consecutive good frames needed before LOCKED asserts
// PORTS
//  BCK      in  1  bit clock, single clock domain, all logic on posedge
//  RSTN     in  1  synchronous reset, active low
//  LRCK     in  1  I2S word clock, low = left
//  DATAIN   in  1  I2S serial data
//  MUTE     in  1  1 = forces zero words at the next commit
//  CLKOUT   out 1  = BCK (combinational pass-through to both DACs)
//  DATAOUTL out 1  left DAC serial data, registered
//  DATAOUTR out 1  right DAC serial data, registered
//  LEOUT    out 1  common latch enable to both DACs, registered
//  LOCKED   out 1  1 = framing locked, registered
//  LED1     out 1  ~LOCKED (0 = LED on)
// BEHAVIOUR
//  Reset (RSTN=0 at posedge): state=SEARCH, fcnt=0, capture/hold regs=0,
//   DATAOUTL/R=0, LEOUT=1, LOCKED=0. Reset mid-frame discards the partial words.
//  lrck_q = LRCK registered. Fall = lrck_q&~LRCK, Rise = ~lrck_q&LRCK, detected at posedge.
//  fcnt: 0..2*SLOT_BITS-1, increments every posedge and wraps. It loads 0 on any Fall
//   in SEARCH, and on a good Fall in ACQUIRE/LOCKED.
//  Capture: left bit b (b=0 MSB) is sampled at posedge with fcnt==b, b<WORD_BITS.
//   Right bit b is sampled at fcnt==SLOT_BITS+b. Bits beyond WORD_BITS are ignored.
//  Framing error (ACQUIRE/LOCKED only), any one of:
//   - Rise with fcnt!=SLOT_BITS-1
//   - Fall with fcnt!=2*SLOT_BITS-1
//   - fcnt==2*SLOT_BITS-1 with no Fall
//  FSM:
//   SEARCH : Fall -> ACQUIRE, good_cnt=0.
//   ACQUIRE: good Fall -> good_cnt+1; at good_cnt==LOCK_FRAMES-1 -> LOCKED.
//            error -> SEARCH.
//   LOCKED : error -> SEARCH; LOCKED deasserts on the next posedge.
//  Commit, at every good Fall: hold_l/hold_r <= captured word[WORD_BITS-1 -:OUT_BITS].
//   Truncation only, no rounding. Zeros are committed instead if the state is not
//   LOCKED or MUTE=1. On error or entry to SEARCH, hold regs clear to 0 at that posedge.
//  Output window, every frame in all states (fcnt free-runs in SEARCH, so DACs keep
//   latching zeros):
//   - DATAOUTx carries hold bit b (MSB first) while fcnt==SLOT_BITS-OUT_BITS+b.
//   - DATAOUTx is 0 outside the window.
//   - LEOUT is 0 while fcnt is in [SLOT_BITS-OUT_BITS, SLOT_BITS-1], else 1.
//     Its rising edge (fcnt becomes SLOT_BITS) latches both DACs together.
//  Latency: a word captured in frame N is committed at the start of frame N+1 and
//   latched when fcnt reaches SLOT_BITS in frame N+1.
//  Hold regs are read only inside the window; a commit at fcnt=0 never tears a word.
// TESTING
//  1 Reset: RSTN low 3 cycles, then 64-BCK frames -> LEOUT=1, DATAOUT=0, LOCKED=0.
//    LOCKED rises after the 4th good Fall; LED1=0.
//  2 Locked data: L=24'hA5F0F3, R=24'h0F1E2D.
//    -> In the next frame, during fcnt 12..31: DATAOUTL=20'hA5F0F, DATAOUTR=20'h0F1E2.
//    -> LEOUT low for exactly 20 cycles.
//  3 Short frame (Fall at fcnt=61) while locked -> LOCKED=0 next cycle.
//    -> The following window shifts zeros. Re-lock after 4 good frames.
//  4 LRCK held static while locked -> error at fcnt=63, SEARCH.
//    -> LE keeps pulsing every 64 cycles with zero data.
//  5 MUTE=1 for one frame with L=R=24'h7FFFFF -> that frame outputs 0; the next shows
//    20'h7FFFF.
//  6 RSTN low at fcnt=20 mid-window -> LEOUT=1 and DATAOUT=0 next cycle, state=SEARCH.

Source files
------------

// File: rtl/i2s_pcm1702_framer.sv
// i2s_pcm1702_framer: frame-locked I2S receiver driving two PCM1702 DACs with a shared latch enable
module i2s_pcm1702_framer #(
    parameter int SLOT_BITS   = 32,
    parameter int WORD_BITS   = 24,
    parameter int OUT_BITS    = 20,
    parameter int LOCK_FRAMES = 4
) (
    input  logic BCK,
    input  logic RSTN,
    input  logic LRCK,
    input  logic DATAIN,
    input  logic MUTE,
    output logic CLKOUT,
    output logic DATAOUTL,
    output logic DATAOUTR,
    output logic LEOUT,
    output logic LOCKED,
    output logic LED1
);
    localparam int FW = $clog2(2 * SLOT_BITS);
    localparam int GW = LOCK_FRAMES > 1 ? $clog2(LOCK_FRAMES) : 1;
    localparam logic [FW-1:0] F_LAST  = FW'(2 * SLOT_BITS - 1);
    localparam logic [FW-1:0] R_EDGE  = FW'(SLOT_BITS - 1);
    localparam logic [FW-1:0] R_BASE  = FW'(SLOT_BITS);
    localparam logic [FW-1:0] W_START = FW'(SLOT_BITS - OUT_BITS);
    localparam logic [FW-1:0] W_LEN   = FW'(WORD_BITS);
    localparam logic [GW-1:0] G_LAST  = GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {S_SEARCH, S_ACQUIRE, S_LOCKED} state_t;

    state_t               state, state_n;
    logic [FW-1:0]        fcnt, fcnt_n, w_off;
    logic [GW-1:0]        good_cnt, good_cnt_n;
    logic [WORD_BITS-1:0] cap_l, cap_r;
    logic [OUT_BITS-1:0]  hold_l, hold_r, hold_l_n, hold_r_n, sh_l, sh_r;
    logic                 lrck_q, fall, rise, last, track, err, good_fall, commit;
    logic                 win, cap_left, cap_right;

    assign CLKOUT = BCK;
    assign LED1   = ~LOCKED;

    always_comb begin
        fall       = lrck_q & ~LRCK;
        rise       = ~lrck_q & LRCK;
        last       = fcnt == F_LAST;
        track      = state != S_SEARCH;
        err        = track && ((rise && fcnt != R_EDGE) || (fall != last));
        good_fall  = track && fall && last;
        fcnt_n     = (last || (fall && !track)) ? '0 : fcnt + FW'(1);
        state_n    = state;
        good_cnt_n = good_cnt;
        if (!track && fall) begin
            state_n    = S_ACQUIRE;
            good_cnt_n = '0;
        end else if (err) begin
            state_n = S_SEARCH;
        end else if (good_fall && state == S_ACQUIRE) begin
            if (good_cnt == G_LAST) state_n = S_LOCKED;
            else good_cnt_n = good_cnt + GW'(1);
        end
        // Words are only published once locked; acquiring frames commit silence
        commit    = state == S_LOCKED && !MUTE;
        hold_l_n  = err ? '0 : good_fall ? (commit ? cap_l[WORD_BITS-1 -: OUT_BITS] : '0) : hold_l;
        hold_r_n  = err ? '0 : good_fall ? (commit ? cap_r[WORD_BITS-1 -: OUT_BITS] : '0) : hold_r;
        // Outputs are registered, so they are aligned to the upcoming count value
        win       = fcnt_n >= W_START && fcnt_n < R_BASE;
        w_off     = fcnt_n - W_START;
        sh_l      = hold_l_n << w_off;
        sh_r      = hold_r_n << w_off;
        cap_left  = fcnt < W_LEN;
        cap_right = fcnt >= R_BASE && (fcnt - R_BASE) < W_LEN;
    end

    always_ff @(posedge BCK) begin
        lrck_q <= LRCK;
        if (!RSTN) begin
            state    <= S_SEARCH;
            fcnt     <= '0;
            good_cnt <= '0;
            cap_l    <= '0;
            cap_r    <= '0;
            hold_l   <= '0;
            hold_r   <= '0;
            DATAOUTL <= 1'b0;
            DATAOUTR <= 1'b0;
            LEOUT    <= 1'b1;
            LOCKED   <= 1'b0;
        end else begin
            state    <= state_n;
            fcnt     <= fcnt_n;
            good_cnt <= good_cnt_n;
            hold_l   <= hold_l_n;
            hold_r   <= hold_r_n;
            if (cap_left) cap_l <= {cap_l[WORD_BITS-2:0], DATAIN};
            if (cap_right) cap_r <= {cap_r[WORD_BITS-2:0], DATAIN};
            DATAOUTL <= win & sh_l[OUT_BITS-1];
            DATAOUTR <= win & sh_r[OUT_BITS-1];
            LEOUT    <= ~win;
            LOCKED   <= state_n == S_LOCKED;
        end
    end
endmodule

// File: tb/tb_i2s_pcm1702_framer.sv
// tb_i2s_pcm1702_framer: frame-level directed vectors plus hand sequences for reset and lock corners
module tb_i2s_pcm1702_framer;
    logic BCK = 1'b0, RSTN = 1'b0, LRCK = 1'b0, DATAIN = 1'b0, MUTE = 1'b0;
    logic CLKOUT, DATAOUTL, DATAOUTR, LEOUT, LOCKED, LED1;
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [23:0] l, r;
        logic        mute;
        int          len;
        logic        flat;
        logic [19:0] el, er;
        logic        lf, ll;
    } vec_t;

    vec_t vecs[20];
    logic [19:0] wl, wr;
    int le_low;
    logic lk_first, lk_last, led_first;

    i2s_pcm1702_framer dut (
        .BCK(BCK), .RSTN(RSTN), .LRCK(LRCK), .DATAIN(DATAIN), .MUTE(MUTE),
        .CLKOUT(CLKOUT), .DATAOUTL(DATAOUTL), .DATAOUTR(DATAOUTR),
        .LEOUT(LEOUT), .LOCKED(LOCKED), .LED1(LED1)
    );

    always #5 BCK = ~BCK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Sample j is taken while the framer count equals j (once aligned), then bit j is driven
    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input logic mute,
                              input int len, input logic flat);
        wl = '0;
        wr = '0;
        le_low = 0;
        for (int j = 0; j < len; j++) begin
            @(negedge BCK);
            if (j == 0) begin
                lk_first  = LOCKED;
                led_first = LED1;
            end
            lk_last = LOCKED;
            if (!LEOUT) le_low++;
            if (j >= 12 && j < 32) begin
                wl = {wl[18:0], DATAOUTL};
                wr = {wr[18:0], DATAOUTR};
            end
            LRCK   = flat ? 1'b0 : (j >= 31 && j <= len - 2);
            DATAIN = j < 24 ? l[23-j] : (j >= 32 && j < 56) ? r[55-j] : 1'b0;
            MUTE   = mute;
        end
    endtask

    initial begin
        vecs[0]  = '{24'h000000, 24'h000000, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0};
        vecs[1]  = '{24'h111111, 24'h222222, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0};
        vecs[2]  = '{24'h000000, 24'h000000, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0};
        vecs[3]  = '{24'h000000, 24'h000000, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0};
        vecs[4]  = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0};
        vecs[5]  = '{24'hA5F0F3, 24'h0F1E2D, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b1, 1'b1};
        vecs[6]  = '{24'h123456, 24'hFEDCBA, 1'b0, 64, 1'b0, 20'hA5F0F, 20'h0F1E2, 1'b1, 1'b1};
        vecs[7]  = '{24'h7FFFFF, 24'h7FFFFF, 1'b1, 64, 1'b0, 20'h12345, 20'hFEDCB, 1'b1, 1'b1};
        vecs[8]  = '{24'h7FFFFF, 24'h7FFFFF, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b1, 1'b1};
        vecs[9]  = '{24'h654321, 24'hABCDEF, 1'b0, 64, 1'b0, 20'h7FFFF, 20'h7FFFF, 1'b1, 1'b1};
        vecs[10] = '{24'h333333, 24'h333333, 1'b0, 62, 1'b0, 20'h65432, 20'hABCDE, 1'b1, 1'b1};
        vecs[11] = '{24'h000000, 24'h000000, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0};
        vecs[12] = '{24'h000000, 24'h000000, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0};
        vecs[13] = '{24'h000000, 24'h000000, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0};
        vecs[14] = '{24'h000000, 24'h000000, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0};
        vecs[15] = '{24'h000000, 24'h000000, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b0, 1'b0};
        vecs[16] = '{24'h89ABCD, 24'h456789, 1'b0, 64, 1'b0, 20'h00000, 20'h00000, 1'b1, 1'b1};
        vecs[17] = '{24'h000000, 24'h000000, 1'b0, 64, 1'b1, 20'h89ABC, 20'h45678, 1'b1, 1'b1};
        vecs[18] = '{24'h000000, 24'h000000, 1'b0, 64, 1'b1, 20'h00000, 20'h00000, 1'b0, 1'b0};
        vecs[19] = '{24'h000000, 24'h000000, 1'b0, 64, 1'b1, 20'h00000, 20'h00000, 1'b0, 1'b0};

        repeat (3) @(negedge BCK);
        chk("rst_leout", LEOUT, 1);
        chk("rst_doutl", DATAOUTL, 0);
        chk("rst_doutr", DATAOUTR, 0);
        chk("rst_locked", LOCKED, 0);
        chk("rst_led1", LED1, 1);
        @(posedge BCK);
        #1;
        chk("clkout_high", CLKOUT, 1);
        RSTN = 1'b1;

        for (int i = 0; i < 20; i++) begin
            send_frame(vecs[i].l, vecs[i].r, vecs[i].mute, vecs[i].len, vecs[i].flat);
            chk($sformatf("f%0d_wordl", i + 1), wl, vecs[i].el);
            chk($sformatf("f%0d_wordr", i + 1), wr, vecs[i].er);
            chk($sformatf("f%0d_le_low", i + 1), le_low, 20);
            chk($sformatf("f%0d_lock_first", i + 1), lk_first, vecs[i].lf);
            chk($sformatf("f%0d_lock_last", i + 1), lk_last, vecs[i].ll);
            chk($sformatf("f%0d_led1", i + 1), led_first, !vecs[i].lf);
        end

        @(negedge BCK);
        RSTN = 1'b0;
        LRCK = 1'b0;
        DATAIN = 1'b0;
        MUTE = 1'b0;
        repeat (3) @(negedge BCK);
        chk("rst2_locked", LOCKED, 0);
        chk("rst2_leout", LEOUT, 1);
        RSTN = 1'b1;
        for (int k = 0; k < 5; k++) send_frame(24'h0, 24'h0, 1'b0, 64, 1'b0);
        chk("relock_last_acq", lk_last, 0);
        send_frame(24'hC0FFEE, 24'hBADA55, 1'b0, 64, 1'b0);
        chk("relock_first", lk_first, 1);
        send_frame(24'h0, 24'h0, 1'b0, 20, 1'b0);
        @(negedge BCK);
        chk("mid_le_before", LEOUT, 0);
        chk("mid_doutl_before", DATAOUTL, 1);
        chk("mid_doutr_before", DATAOUTR, 1);
        RSTN = 1'b0;
        @(negedge BCK);
        chk("mid_le_after", LEOUT, 1);
        chk("mid_doutl_after", DATAOUTL, 0);
        chk("mid_doutr_after", DATAOUTR, 0);
        chk("mid_locked_after", LOCKED, 0);
        RSTN = 1'b1;
        send_frame(24'h0, 24'h0, 1'b0, 64, 1'b0);
        send_frame(24'h0, 24'h0, 1'b0, 64, 1'b0);
        chk("post_rst_search", lk_first, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
